prog_mem_arbiter: RTL and testbench
===================================

Name: prog_mem_arbiter

Overview:
- Shares the single-port program memory between the CPU instruction-fetch port (A/I) and an external loader/debug master.
- When the loader requests, the block:
  - stalls the CPU through n_halt;
  - waits for the fetch/halt path to settle;
  - grants the loader exclusive memory access;
  - then hands the memory back to the CPU.
- Sits between the CPU core and the program RAM, in the FPGA top level.

Parameters:
- ADDR_W, 13, program memory address width; the CPU A[ADDR_W-1:0] is used and upper bits are ignored.
- DATA_W, 16, instruction word width.
- DRAIN_CYCLES, 4, cycles n_halt is held low before the grant is issued (range 1..15).
- MIN_RUN, 8, minimum CPU-owned cycles after a resume before the next halt may start (range 0..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- cpu_A  in  16  CPU fetch address.
- cpu_I  out  DATA_W  instruction word to CPU.
- cpu_n_halt  out  1  active-low halt request to CPU.
- ld_req  in  1  loader requests the memory; level, held until the loader is done.
- ld_gnt  out  1  loader owns the memory.
- ld_we  in  1  loader write strobe; honoured only while ld_gnt=1.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_rdata  out  DATA_W  loader read data; equals mem_rdata.
- mem_addr  out  ADDR_W  RAM address (combinational mux).
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; synchronous RAM, 1-cycle read latency.

Behaviour:
- Reset (n_reset=0, asynchronous):
  - state=RUN, drain counter=0, run counter=MIN_RUN (so a halt is permitted immediately after reset);
  - outputs: cpu_n_halt=1, ld_gnt=0, mem_we=0.
  - Reset mid-operation (any state) aborts immediately to these values. Any in-flight loader write is dropped.
- States and transitions (evaluated at each rising edge):
  - RUN: mem_addr=cpu_A[ADDR_W-1:0]; cpu_I=mem_rdata.
    - If ld_req=1 and run counter>=MIN_RUN: go to HALT_WAIT and load drain counter=DRAIN_CYCLES-1.
    - Run counter increments each RUN cycle and saturates at MIN_RUN.
  - HALT_WAIT: cpu_n_halt=0; mem_addr still cpu_A; cpu_I=16'h0000 (NOP = MOVE R0,R0).
    - Drain counter decrements each cycle. At 0 with ld_req=1: go to GRANT.
    - If ld_req drops before the grant: go to RESUME (abort). No grant is issued.
  - GRANT: cpu_n_halt=0; ld_gnt=1; mem_addr=ld_addr; mem_we=ld_we; mem_wdata=ld_wdata; cpu_I=16'h0000.
    - Stays in GRANT while ld_req=1. On ld_req=0: go to RESUME.
  - RESUME: cpu_n_halt=1; ld_gnt=0; mem_addr=cpu_A; cpu_I=16'h0000 for this one cycle (the RAM output still holds the loader read).
    - Next state RUN; clear run counter to 0.
- Output registration:
  - ld_gnt and cpu_n_halt are registered state decodes.
  - mem_addr, mem_we and mem_wdata are combinational from the state register.
  - mem_we is never 1 outside GRANT.
- Loader reads: ld_rdata is valid the cycle after ld_addr is presented in GRANT.
- Loader handshake: the loader must not drive ld_we until it samples ld_gnt=1.
  - A write presented in the same cycle ld_req falls is still performed if state=GRANT.
- Latency:
  - ld_req rise to ld_gnt=1 is DRAIN_CYCLES+1 cycles when run counter>=MIN_RUN.
  - Otherwise the request waits in RUN until the counter saturates.
- Starvation: MIN_RUN guarantees the CPU at least MIN_RUN fetch cycles between loader tenures, even if ld_req is held continuously.
- Simultaneous events:
  - ld_req rising in the RESUME cycle is ignored until the RUN/MIN_RUN rule allows it.
  - ld_req toggling within HALT_WAIT: only the level at the decision edge matters.

Test Plan:
- Reset release, ld_req=0, cpu_A=0x0012, RAM[0x12]=0xABCD -> cpu_I=0xABCD one cycle later; cpu_n_halt=1, ld_gnt=0 throughout.
- ld_req=1 at cycle T with DRAIN_CYCLES=4 -> cpu_n_halt=0 at T+1; ld_gnt=1 at T+5; cpu_I=0x0000 from T+1 until RUN resumes.
- In GRANT, write 0x1F00 to addr 0x0100 then read 0x0100 -> ld_rdata=0x1F00 one cycle after the read address; drop ld_req -> one RESUME cycle (cpu_n_halt=1, cpu_I=0x0000), then RUN with the CPU fetching 0x0100 and receiving 0x1F00.
- ld_req held high continuously with MIN_RUN=8 -> at least 8 consecutive RUN cycles between each RESUME and the next HALT_WAIT; a grant occurs every tenure.
- ld_req pulsed for 2 cycles (shorter than DRAIN_CYCLES) -> ld_gnt never asserted; cpu_n_halt returns to 1 via RESUME; no mem_we.
- n_reset asserted mid-GRANT with ld_we=1 -> cpu_n_halt=1, ld_gnt=0, mem_we=0 immediately (asynchronous); after release the state is RUN and a new ld_req is granted after DRAIN_CYCLES+1 cycles.

Source files
------------

// File: rtl/prog_mem_arbiter.sv
// Program memory arbiter: the CPU fetch port owns the single-port RAM by
// default. A loader request halts the CPU, lets the fetch path drain, grants
// the loader exclusive access, then hands the RAM back. After a hand-back the
// CPU is guaranteed a minimum number of fetch cycles before the next halt.
module prog_mem_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 16,
    parameter int DRAIN_CYCLES = 4,
    parameter int MIN_RUN      = 8
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [15:0]       cpu_A,
    output logic [DATA_W-1:0] cpu_I,
    output logic              cpu_n_halt,
    input  logic              ld_req,
    output logic              ld_gnt,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {RUN, HALT_WAIT, GRANT, RESUME} state_t;

    // Drain counter is loaded with DRAIN_CYCLES-1 so that the grant lands
    // exactly DRAIN_CYCLES halted cycles after the halt starts.
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam logic [7:0] RUN_SAT    = 8'(MIN_RUN);

    state_t     state, state_nxt;
    logic [3:0] drain_cnt, drain_nxt;
    logic [7:0] run_cnt, run_nxt;
    logic       run_ok;
    logic       in_grant;

    // Address bits above the RAM size are ignored by design.
    logic       unused_cpu_a_hi;
    assign unused_cpu_a_hi = ^cpu_A[15:ADDR_W];

    assign run_ok   = (run_cnt >= RUN_SAT);
    assign in_grant = (state == GRANT);

    // Next-state and counter update logic.
    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        run_nxt   = run_cnt;
        case (state)
            RUN: begin
                if (run_cnt < RUN_SAT) run_nxt = run_cnt + 8'd1;
                if (ld_req && run_ok) begin
                    state_nxt = HALT_WAIT;
                    drain_nxt = DRAIN_LOAD;
                end
            end
            HALT_WAIT: begin
                // A dropped request aborts the halt without ever granting.
                if (!ld_req)               state_nxt = RESUME;
                else if (drain_cnt == 4'd0) state_nxt = GRANT;
                else                       drain_nxt = drain_cnt - 4'd1;
            end
            GRANT: begin
                if (!ld_req) state_nxt = RESUME;
            end
            RESUME: begin
                state_nxt = RUN;
                run_nxt   = 8'd0;
            end
            default: state_nxt = RUN;
        endcase
    end

    // State, counters and registered halt/grant decodes.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= RUN;
            drain_cnt  <= 4'd0;
            run_cnt    <= RUN_SAT;
            cpu_n_halt <= 1'b1;
            ld_gnt     <= 1'b0;
        end else begin
            state      <= state_nxt;
            drain_cnt  <= drain_nxt;
            run_cnt    <= run_nxt;
            cpu_n_halt <= !((state_nxt == HALT_WAIT) || (state_nxt == GRANT));
            ld_gnt     <= (state_nxt == GRANT);
        end
    end

    // RAM port mux; the CPU sees NOPs whenever the RAM output is not its own
    // fetch (halted, granted, or the hand-back cycle holding loader data).
    always_comb begin
        mem_addr  = in_grant ? ld_addr : cpu_A[ADDR_W-1:0];
        mem_we    = in_grant && ld_we;
        mem_wdata = in_grant ? ld_wdata : '0;
        cpu_I     = (state == RUN) ? mem_rdata : '0;
        ld_rdata  = mem_rdata;
    end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Bench for prog_mem_arbiter: a directed vector table, hand sequences for
// the multi-cycle corners, and randomized traffic against an ownership model.
module tb_prog_mem_arbiter;
    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 16;
    localparam int DRAIN   = 4;
    localparam int MIN_RUN = 8;

    localparam int OWN_CPU  = 0;
    localparam int OWN_DRN  = 1;
    localparam int OWN_LDR  = 2;
    localparam int OWN_BACK = 3;

    logic              clk = 1'b0;
    logic              n_reset;
    logic [15:0]       cpu_A;
    logic [DATA_W-1:0] cpu_I;
    logic              cpu_n_halt;
    logic              ld_req;
    logic              ld_gnt;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic [DATA_W-1:0] ld_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    prog_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DRAIN_CYCLES(DRAIN), .MIN_RUN(MIN_RUN)) dut (
        .clk(clk), .n_reset(n_reset), .cpu_A(cpu_A), .cpu_I(cpu_I), .cpu_n_halt(cpu_n_halt),
        .ld_req(ld_req), .ld_gnt(ld_gnt), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [15:0] pat(int i);
        logic [15:0] v;
        v = 16'(i * 40503) ^ 16'h5A5A;
        if (i == 'h12) v = 16'hABCD;
        return v;
    endfunction

    // Synchronous single-port RAM driven by the DUT.
    logic [15:0] ram [0:8191];
    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = pat(i);
        forever begin
            @(posedge clk);
            mem_rdata <= ram[mem_addr];
            if (mem_we) ram[mem_addr] <= mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_ram [0:8191];
    int          m_own, m_run_done, m_drained;
    logic [15:0] m_rd;
    bit          m_rd_ok;
    int          n_cmp, n_err;
    bit          obs_nh, obs_gnt, obs_we;

    task automatic m_reset();
        m_own      = OWN_CPU;
        m_run_done = MIN_RUN;
        m_drained  = 0;
    endtask

    // Advance one clock edge: who owned the RAM this cycle decides what was
    // read and written; then ownership moves on by elapsed-cycle counts.
    task automatic m_advance();
        logic [12:0] a;
        a = (m_own == OWN_LDR) ? ld_addr : cpu_A[12:0];
        m_rd    = ref_ram[a];
        m_rd_ok = 1'b1;
        if (m_own == OWN_LDR && ld_we) ref_ram[a] = ld_wdata;
        if (!n_reset) m_reset();
        else begin
            case (m_own)
                OWN_CPU: if (ld_req && m_run_done >= MIN_RUN) begin
                    m_own = OWN_DRN; m_drained = 0;
                end else m_run_done++;
                OWN_DRN: begin
                    m_drained++;
                    if (!ld_req) m_own = OWN_BACK;
                    else if (m_drained == DRAIN) m_own = OWN_LDR;
                end
                OWN_LDR: if (!ld_req) m_own = OWN_BACK;
                default: begin m_own = OWN_CPU; m_run_done = 0; end
            endcase
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_check();
        bit halted;
        halted = (m_own == OWN_DRN) || (m_own == OWN_LDR);
        chk("n_halt", 32'(cpu_n_halt), 32'(!halted));
        chk("ld_gnt", 32'(ld_gnt), 32'(m_own == OWN_LDR));
        chk("mem_we", 32'(mem_we), 32'((m_own == OWN_LDR) && ld_we));
        chk("mem_addr", 32'(mem_addr), 32'((m_own == OWN_LDR) ? ld_addr : cpu_A[12:0]));
        if (m_own == OWN_LDR) chk("mem_wdata", 32'(mem_wdata), 32'(ld_wdata));
        if (m_own != OWN_CPU) chk("cpu_I_nop", 32'(cpu_I), 32'h0);
        else if (m_rd_ok) chk("cpu_I", 32'(cpu_I), 32'(m_rd));
        if (m_rd_ok) chk("ld_rdata", 32'(ld_rdata), 32'(m_rd));
        obs_nh  = cpu_n_halt;
        obs_gnt = ld_gnt;
        obs_we  = mem_we;
    endtask

    // One cycle: inputs already applied; check mid-cycle, then clock.
    task automatic tick();
        @(negedge clk);
        m_check();
        @(posedge clk);
        m_advance();
        #1;
    endtask

    task automatic drive(input bit req, input bit we, input logic [15:0] a,
                         input logic [12:0] la, input logic [15:0] wd);
        ld_req = req; ld_we = we; cpu_A = a; ld_addr = la; ld_wdata = wd;
    endtask

    typedef struct {
        bit req; bit we; logic [15:0] a; logic [12:0] la; logic [15:0] wd;
        bit e_nh; bit e_gnt; bit e_we; bit ci_c; logic [15:0] e_ci; bit rd_c; logic [15:0] e_rd;
    } vec_t;

    function automatic vec_t v(bit req, bit we, logic [15:0] a, logic [12:0] la, logic [15:0] wd,
                               bit nh, bit g, bit w, bit cic, logic [15:0] ci, bit rdc, logic [15:0] rd);
        vec_t r;
        r.req = req; r.we = we; r.a = a; r.la = la; r.wd = wd;
        r.e_nh = nh; r.e_gnt = g; r.e_we = w; r.ci_c = cic; r.e_ci = ci; r.rd_c = rdc; r.e_rd = rd;
        return r;
    endfunction

    initial begin
        vec_t tv[$];
        int   lat, high_len, tenures, grants, gnt_run;
        bit   saw_gnt, had_tenure, any_gnt, any_we, saw_low, prev_nh;
        n_cmp = 0; n_err = 0; m_rd_ok = 1'b0;
        for (int i = 0; i < 8192; i++) ref_ram[i] = pat(i);
        n_reset = 1'b0;
        drive(0, 0, 16'h0012, 13'h0, 16'h0);
        m_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_n_halt", 32'(obs_nh), 32'h1);
        chk("rst_gnt", 32'(obs_gnt), 32'h0);
        n_reset = 1'b1;

        // Directed: fetch, halt, grant, write/read, hand-back.
        tv.push_back(v(0, 0, 16'h0012, 13'h000, 16'h0000, 1, 0, 0, 1, 16'hABCD, 0, 16'h0));
        tv.push_back(v(0, 0, 16'h0012, 13'h000, 16'h0000, 1, 0, 0, 1, 16'hABCD, 0, 16'h0));
        tv.push_back(v(1, 0, 16'h0012, 13'h000, 16'h0000, 1, 0, 0, 1, 16'hABCD, 0, 16'h0));
        for (int i = 0; i < DRAIN; i++)
            tv.push_back(v(1, 0, 16'h0012, 13'h000, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 16'h0));
        tv.push_back(v(1, 1, 16'h0012, 13'h100, 16'h1F00, 0, 1, 1, 1, 16'h0000, 0, 16'h0));
        tv.push_back(v(1, 0, 16'h0012, 13'h100, 16'h0000, 0, 1, 0, 1, 16'h0000, 0, 16'h0));
        tv.push_back(v(1, 0, 16'h0012, 13'h100, 16'h0000, 0, 1, 0, 1, 16'h0000, 1, 16'h1F00));
        tv.push_back(v(0, 1, 16'h0100, 13'h200, 16'h4242, 0, 1, 1, 1, 16'h0000, 0, 16'h0));
        tv.push_back(v(0, 0, 16'h0100, 13'h000, 16'h0000, 1, 0, 0, 1, 16'h0000, 0, 16'h0));
        tv.push_back(v(0, 0, 16'h0200, 13'h000, 16'h0000, 1, 0, 0, 1, 16'h1F00, 0, 16'h0));
        tv.push_back(v(0, 0, 16'h0200, 13'h000, 16'h0000, 1, 0, 0, 1, 16'h4242, 0, 16'h0));
        foreach (tv[i]) begin
            drive(tv[i].req, tv[i].we, tv[i].a, tv[i].la, tv[i].wd);
            @(negedge clk);
            chk($sformatf("vec%0d_n_halt", i), 32'(cpu_n_halt), 32'(tv[i].e_nh));
            chk($sformatf("vec%0d_gnt", i), 32'(ld_gnt), 32'(tv[i].e_gnt));
            chk($sformatf("vec%0d_we", i), 32'(mem_we), 32'(tv[i].e_we));
            if (tv[i].ci_c) chk($sformatf("vec%0d_cpu_I", i), 32'(cpu_I), 32'(tv[i].e_ci));
            if (tv[i].rd_c) chk($sformatf("vec%0d_rdata", i), 32'(ld_rdata), 32'(tv[i].e_rd));
            m_check();
            @(posedge clk);
            m_advance();
            #1;
        end

        // Loader re-requests immediately after every tenure: CPU must still
        // get its minimum run between tenures, and every tenure is granted.
        high_len = 0; tenures = 0; grants = 0; gnt_run = 0;
        saw_gnt = 0; had_tenure = 0; prev_nh = 1;
        for (int c = 0; c < 120; c++) begin
            drive(gnt_run != 3, 0, 16'h0040, 13'h0, 16'h0);
            tick();
            gnt_run = obs_gnt ? gnt_run + 1 : 0;
            if (obs_gnt) saw_gnt = 1;
            if (obs_nh) high_len++;
            if (prev_nh && !obs_nh) begin
                if (had_tenure) chk("starve_gap", 32'(high_len >= MIN_RUN + 1), 32'h1);
                tenures++;
            end
            if (!prev_nh && obs_nh) begin
                had_tenure = 1; high_len = 1;
                if (saw_gnt) grants++;
                saw_gnt = 0;
            end
            prev_nh = obs_nh;
        end
        chk("starve_tenures", 32'(tenures >= 3), 32'h1);
        chk("starve_grants", 32'(grants), 32'(tenures - (prev_nh ? 0 : 1)));

        // Short request pulse aborts the halt with no grant and no write.
        drive(0, 0, 16'h0012, 13'h0, 16'h0);
        for (int c = 0; c < 14; c++) tick();
        any_gnt = 0; any_we = 0; saw_low = 0;
        for (int c = 0; c < 12; c++) begin
            drive(c < 2, 1, 16'h0012, 13'h055, 16'hFFFF);
            tick();
            any_gnt |= obs_gnt; any_we |= obs_we; saw_low |= !obs_nh;
        end
        chk("pulse_no_gnt", 32'(any_gnt), 32'h0);
        chk("pulse_no_we", 32'(any_we), 32'h0);
        chk("pulse_halted", 32'(saw_low), 32'h1);
        chk("pulse_resumed", 32'(obs_nh), 32'h1);

        // Reset in the middle of a write tenure.
        lat = 0;
        drive(1, 0, 16'h0012, 13'h300, 16'h0);
        while (!obs_gnt && lat < 30) begin tick(); lat++; end
        chk("rst_pre_gnt", 32'(obs_gnt), 32'h1);
        drive(1, 1, 16'h0012, 13'h300, 16'hDEAD);
        tick();
        drive(1, 1, 16'h0012, 13'h301, 16'hBEEF);
        n_reset = 1'b0;
        m_reset();
        #1;
        chk("async_n_halt", 32'(cpu_n_halt), 32'h1);
        chk("async_gnt", 32'(ld_gnt), 32'h0);
        chk("async_we", 32'(mem_we), 32'h0);
        tick();
        drive(0, 0, 16'h0012, 13'h0, 16'h0);
        tick();
        n_reset = 1'b1;
        lat = 0;
        drive(1, 0, 16'h0301, 13'h301, 16'h0);
        tick();
        while (!obs_gnt && lat < 30) begin tick(); lat++; end
        chk("rst_regrant_lat", 32'(lat), 32'(DRAIN + 1));
        drive(0, 0, 16'h0301, 13'h0, 16'h0);
        for (int c = 0; c < 3; c++) tick();

        // Randomized traffic against the model, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) ld_req = !ld_req;
            ld_we    = 1'($urandom_range(0, 1));
            ld_addr  = 13'($urandom_range(0, 63));
            ld_wdata = 16'($urandom);
            cpu_A    = 16'($urandom) & 16'hE03F;
            if (!n_reset) n_reset = 1'b1;
            else if ($urandom_range(0, 599) == 0) begin
                n_reset = 1'b0;
                m_reset();
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
